// File: rtl/quad_io_pkg.sv
// Shared constants and types for the quadcore output arbiter.
// Holds the default core count, data width and per-core port count,
// the index-width helper and the slot-entry layout {addr, data}.
package quad_io_pkg;

    localparam int NUBITS_DEF = 32;
    localparam int NCORE_DEF  = 4;
    localparam int NUIOOU_DEF = 2;
    localparam int FDEPTH_DEF = 2;

    // Index width for a set of n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CORE_W = idx_width(NCORE_DEF);
    localparam int ADDR_W = idx_width(NUIOOU_DEF);

    typedef struct packed {
        logic [ADDR_W-1:0]     addr;
        logic [NUBITS_DEF-1:0] data;
    } slot_entry_t;

endpackage

// File: rtl/quad_out_arb_if.sv
// Valid/ready output port of the quadcore output arbiter.
// master drives the word, slave (the sink) drives m_ready.
interface quad_out_arb_if
    import quad_io_pkg::*;
#(
    parameter int NUBITS = NUBITS_DEF,
    parameter int CORE_W = quad_io_pkg::CORE_W,
    parameter int ADDR_W = quad_io_pkg::ADDR_W
);

    logic              m_valid;
    logic              m_ready;
    logic [NUBITS-1:0] m_data;
    logic [CORE_W-1:0] m_core;
    logic [ADDR_W-1:0] m_addr;

    modport master (
        output m_valid,
        output m_data,
        output m_core,
        output m_addr,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_core,
        input  m_addr,
        output m_ready
    );

endinterface

// File: rtl/io_slot_fifo.sv
// Per-core slot FIFO. Pointers carry one extra wrap bit so full and
// empty can be told apart; a push into a full FIFO is accepted only
// when the same cycle also pops. Reset is asynchronous, active-low.
module io_slot_fifo
    import quad_io_pkg::*;
#(
    parameter int WIDTH  = 33,
    parameter int FDEPTH = FDEPTH_DEF
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(FDEPTH) + 1;
    localparam int IW = PW - 1;

    logic [WIDTH-1:0] r_mem [FDEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                       (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr[IW-1:0]];

    // Advance the read and write pointers on accepted pops and pushes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Store accepted entries; storage needs no reset since empty gates reads.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[IW-1:0]] <= din;
    end

endmodule

// File: rtl/quad_out_arb.sv
// Output arbiter for the quadcore build. Each core's one-hot output
// strobe pushes {lowest set port index, data} into its own slot FIFO;
// a round-robin arbiter drains the FIFOs into a registered valid/ready
// output stage. Pushes into a full, unpopped FIFO are dropped and flagged
// in the sticky ovf bits.
// Build option: define QARB_FIXPRI_EN for fixed priority (core 0 highest,
// no round-robin pointer); undefined gives round-robin arbitration.
module quad_out_arb
    import quad_io_pkg::*;
#(
    parameter int NUBITS = NUBITS_DEF,
    parameter int NCORE  = NCORE_DEF,
    parameter int NUIOOU = NUIOOU_DEF,
    parameter int FDEPTH = FDEPTH_DEF
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCORE*NUBITS-1:0]  core_data,
    input  logic [NCORE*NUIOOU-1:0]  core_out_en,
    quad_out_arb_if.master           m,
    output logic [NCORE-1:0]         ovf,
    input  logic                     ovf_clr
);

    localparam int CW = idx_width(NCORE);
    localparam int AW = idx_width(NUIOOU);
    localparam int EW = AW + NUBITS;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [NCORE-1:0]  w_push;
    logic [NCORE-1:0]  w_pop;
    logic [NCORE-1:0]  w_full;
    logic [NCORE-1:0]  w_empty;
    logic [NCORE-1:0]  w_drop;
    logic [AW-1:0]     w_push_addr [NCORE];
    logic [EW-1:0]     w_din       [NCORE];
    logic [EW-1:0]     w_dout      [NCORE];
    logic [EW-1:0]     w_sel;
    logic              w_load;
    logic              w_grant_valid;
    logic [CW-1:0]     w_grant_idx;

    logic [0:0]        r_state;
    logic [NUBITS-1:0] r_data;
    logic [CW-1:0]     r_core;
    logic [AW-1:0]     r_addr;
    logic [NCORE-1:0]  r_ovf;
`ifndef QARB_FIXPRI_EN
    logic [CW-1:0]     r_rr_last;
`endif

    // Decode each core's strobe into a push request and its lowest set port.
    always_comb begin
        for (int i = 0; i < NCORE; i++) begin
            w_push[i]      = |core_out_en[i*NUIOOU +: NUIOOU];
            w_push_addr[i] = '0;
            for (int j = NUIOOU - 1; j >= 0; j--) begin
                if (core_out_en[i*NUIOOU + j]) w_push_addr[i] = AW'(j);
            end
            w_din[i] = {w_push_addr[i], core_data[i*NUBITS +: NUBITS]};
        end
    end

    for (genvar g = 0; g < NCORE; g++) begin : g_slot
        io_slot_fifo #(
            .WIDTH  (EW),
            .FDEPTH (FDEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (w_push[g]),
            .pop   (w_pop[g]),
            .din   (w_din[g]),
            .dout  (w_dout[g]),
            .full  (w_full[g]),
            .empty (w_empty[g])
        );
    end

    assign w_load = (r_state == S_IDLE) || m.m_ready;

    // Pick the first non-empty FIFO; scanning from far to near leaves the nearest.
    always_comb begin
        logic [CW-1:0] w_cand;
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
`ifdef QARB_FIXPRI_EN
        for (int k = NCORE - 1; k >= 0; k--) begin
            w_cand = CW'(k);
            if (!w_empty[w_cand]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
`else
        for (int k = NCORE; k >= 1; k--) begin
            w_cand = CW'((int'(r_rr_last) + k) % NCORE);
            if (!w_empty[w_cand]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
`endif
    end

    assign w_sel = w_dout[w_grant_idx];

    // Pop the granted FIFO and flag pushes that find no room.
    always_comb begin
        for (int i = 0; i < NCORE; i++) begin
            w_pop[i]  = w_load && w_grant_valid && (w_grant_idx == CW'(i));
            w_drop[i] = w_push[i] && w_full[i] && !w_pop[i];
        end
    end

    // Output stage: load the granted entry or fall idle at each load opportunity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_core  <= '0;
            r_addr  <= '0;
        end else if (w_load) begin
            if (w_grant_valid) begin
                r_state <= S_HOLD;
                r_data  <= w_sel[NUBITS-1:0];
                r_addr  <= w_sel[EW-1:NUBITS];
                r_core  <= w_grant_idx;
            end else begin
                r_state <= S_IDLE;
            end
        end
    end

`ifndef QARB_FIXPRI_EN
    // Remember the last granted core so the next search starts just after it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_last <= CW'(NCORE - 1);
        end else if (w_load && w_grant_valid) begin
            r_rr_last <= w_grant_idx;
        end
    end
`endif

    // Sticky drop flags; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= w_drop | (r_ovf & ~{NCORE{ovf_clr}});
        end
    end

    assign m.m_valid = (r_state == S_HOLD);
    assign m.m_data  = r_data;
    assign m.m_core  = r_core;
    assign m.m_addr  = r_addr;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_quad_out_arb.sv
// Self-checking bench for quad_out_arb: directed scenarios plus random
// traffic, all compared each cycle against a queue-based reference model.
module tb_quad_out_arb;
    import quad_io_pkg::*;

    localparam int NC = 4;
    localparam int NB = 32;
    localparam int NU = 2;
    localparam int FD = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [NC*NB-1:0] coreData;
    logic [NC*NU-1:0] coreOutEn;
    logic           ovfClr;
    logic [NC-1:0]  ovf;

    quad_out_arb_if #(.NUBITS(NB), .CORE_W(2), .ADDR_W(1)) bus ();

    quad_out_arb #(
        .NUBITS (NB),
        .NCORE  (NC),
        .NUIOOU (NU),
        .FDEPTH (FD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .core_data   (coreData),
        .core_out_en (coreOutEn),
        .m           (bus),
        .ovf         (ovf),
        .ovf_clr     (ovfClr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    slot_entry_t    mdlQ [NC][$];
    bit             mdlValid;
    logic [NB-1:0]  mdlData;
    int             mdlCore;
    int             mdlAddr;
    logic [NC-1:0]  mdlOvf;
    int             mdlRrLast;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NC; i++) mdlQ[i].delete();
        mdlValid  = 1'b0;
        mdlData   = '0;
        mdlCore   = 0;
        mdlAddr   = 0;
        mdlOvf    = '0;
        mdlRrLast = NC - 1;
    endtask

    // One clock of the reference: pick a grant, pop, push with capacity limit, update output.
    task automatic modelStep(input logic [NC*NU-1:0] en, input logic [NC*NB-1:0] data,
                             input logic ready, input logic clr);
        bit            load;
        int            grant;
        int            c;
        slot_entry_t   popped;
        slot_entry_t   entry;
        logic [NU-1:0] slice;
        logic [NC-1:0] newOvf;
        load   = !mdlValid || ready;
        grant  = -1;
        popped = '0;
        if (load) begin
            for (int k = 0; k < NC; k++) begin
`ifdef QARB_FIXPRI_EN
                c = k;
`else
                c = (mdlRrLast + 1 + k) % NC;
`endif
                if (grant < 0 && mdlQ[c].size() > 0) grant = c;
            end
        end
        if (grant >= 0) popped = mdlQ[grant].pop_front();
        newOvf = clr ? '0 : mdlOvf;
        for (int i = 0; i < NC; i++) begin
            slice = en[i*NU +: NU];
            if (slice != '0) begin
                entry = '0;
                for (int j = NU - 1; j >= 0; j--) if (slice[j]) entry.addr = ADDR_W'(j);
                entry.data = data[i*NB +: NB];
                if (mdlQ[i].size() < FD) mdlQ[i].push_back(entry);
                else newOvf[i] = 1'b1;
            end
        end
        mdlOvf = newOvf;
        if (load) begin
            if (grant >= 0) begin
                mdlValid  = 1'b1;
                mdlData   = popped.data;
                mdlCore   = grant;
                mdlAddr   = int'(popped.addr);
                mdlRrLast = grant;
            end else begin
                mdlValid = 1'b0;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("m_valid", 64'(bus.m_valid), 64'(mdlValid));
        checkOutput("m_data",  64'(bus.m_data),  64'(mdlData));
        checkOutput("m_core",  64'(bus.m_core),  64'(mdlCore));
        checkOutput("m_addr",  64'(bus.m_addr),  64'(mdlAddr));
        checkOutput("ovf",     64'(ovf),         64'(mdlOvf));
    endtask

    // At each falling edge: compare against the model, then drive the next cycle's inputs.
    task automatic applyStimulus(input logic [NC*NU-1:0] en, input logic [NC*NB-1:0] data,
                                 input logic ready, input logic clr);
        @(negedge clk);
        checkAll();
        coreOutEn   = en;
        coreData    = data;
        bus.m_ready = ready;
        ovfClr      = clr;
        modelStep(en, data, ready, clr);
    endtask

    task automatic idle(input logic ready);
        applyStimulus('0, {$urandom, $urandom, $urandom, $urandom}, ready, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst       = 1'b0;
        coreOutEn = '0;
        ovfClr    = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [NC*NB-1:0] packData(input logic [NB-1:0] d0, input logic [NB-1:0] d1,
                                                  input logic [NB-1:0] d2, input logic [NB-1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    initial begin
        logic [NC*NU-1:0] en;
        logic [NB-1:0]    expData [4];
        int               expCore [4];

        rst         = 1'b0;
        coreOutEn   = '0;
        coreData    = '0;
        ovfClr      = 1'b0;
        bus.m_ready = 1'b0;
        modelReset();
        #1;
        checkOutput("reset m_valid", 64'(bus.m_valid), 64'd0);
        checkOutput("reset m_data",  64'(bus.m_data),  64'd0);
        checkOutput("reset m_core",  64'(bus.m_core),  64'd0);
        checkOutput("reset m_addr",  64'(bus.m_addr),  64'd0);
        checkOutput("reset ovf",     64'(ovf),         64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Single word from core 2, port 1.
        repeat (3) idle(1'b1);
        applyStimulus(8'b0010_0000, packData(0, 0, 32'h0000_1234, 0), 1'b1, 1'b0);
        idle(1'b1);
        checkOutput("single early", 64'(bus.m_valid), 64'd0);
        idle(1'b1);
        checkOutput("single valid", 64'(bus.m_valid), 64'd1);
        checkOutput("single data",  64'(bus.m_data),  64'h1234);
        checkOutput("single core",  64'(bus.m_core),  64'd2);
        checkOutput("single addr",  64'(bus.m_addr),  64'd1);
        idle(1'b1);
        checkOutput("single once",  64'(bus.m_valid), 64'd0);

        // All four cores at once drain in core order 0..3.
        doReset();
        applyStimulus(8'b0101_0101, packData(32'hA0, 32'hA1, 32'hA2, 32'hA3), 1'b1, 1'b0);
        idle(1'b1);
        for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            checkOutput("rr valid", 64'(bus.m_valid), 64'd1);
            checkOutput("rr data",  64'(bus.m_data),  64'(32'hA0 + k));
            checkOutput("rr core",  64'(bus.m_core),  64'(k));
        end
        idle(1'b1);

`ifdef QARB_FIXPRI_EN
        // Fixed priority: both core-0 words precede both core-3 words.
        doReset();
        applyStimulus(8'b0100_0001, packData(32'hB0, 0, 0, 32'hC0), 1'b1, 1'b0);
        applyStimulus(8'b0100_0001, packData(32'hB1, 0, 0, 32'hC1), 1'b1, 1'b0);
        expData = '{32'hB0, 32'hB1, 32'hC0, 32'hC1};
        expCore = '{0, 0, 3, 3};
        for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            checkOutput("fixpri data", 64'(bus.m_data), 64'(expData[k]));
            checkOutput("fixpri core", 64'(bus.m_core), 64'(expCore[k]));
        end
`else
        // Round-robin: cores 0 and 3 alternate.
        doReset();
        applyStimulus(8'b0100_0001, packData(32'hB0, 0, 0, 32'hC0), 1'b1, 1'b0);
        applyStimulus(8'b0100_0001, packData(32'hB1, 0, 0, 32'hC1), 1'b1, 1'b0);
        expData = '{32'hB0, 32'hC0, 32'hB1, 32'hC1};
        expCore = '{0, 3, 0, 3};
        for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            checkOutput("rr2 data", 64'(bus.m_data), 64'(expData[k]));
            checkOutput("rr2 core", 64'(bus.m_core), 64'(expCore[k]));
        end
`endif
        idle(1'b1);

        // Backpressure: word held stable for ten stalled cycles, then drains in order.
        doReset();
        applyStimulus(8'b0000_0100, packData(0, 32'h55, 0, 0), 1'b0, 1'b0);
        applyStimulus(8'b0000_0100, packData(0, 32'h56, 0, 0), 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            idle(1'b0);
            checkOutput("bp valid", 64'(bus.m_valid), 64'd1);
            checkOutput("bp data",  64'(bus.m_data),  64'h55);
            checkOutput("bp core",  64'(bus.m_core),  64'd1);
            checkOutput("bp addr",  64'(bus.m_addr),  64'd0);
        end
        idle(1'b1);
        idle(1'b1);
        checkOutput("bp drain", 64'(bus.m_data), 64'h56);
        idle(1'b1);
        checkOutput("bp empty", 64'(bus.m_valid), 64'd0);

        // Overflow on core 1, set beats clear, then clear alone.
        doReset();
        for (int k = 0; k < 4; k++)
            applyStimulus(8'b0000_0100, packData(0, 32'h100 + k, 0, 0), 1'b0, 1'b0);
        applyStimulus(8'b0000_0100, packData(0, 32'h104, 0, 0), 1'b0, 1'b1);
        checkOutput("ovf set",      64'(ovf),        64'b0010);
        checkOutput("ovf held",     64'(bus.m_data), 64'h100);
        applyStimulus('0, '0, 1'b0, 1'b1);
        checkOutput("ovf set wins", 64'(ovf),        64'b0010);
        idle(1'b1);
        checkOutput("ovf cleared",  64'(ovf),        64'd0);
        for (int k = 1; k < 3; k++) begin
            idle(1'b1);
            checkOutput("ovf drain", 64'(bus.m_data), 64'(32'h100 + k));
        end
        idle(1'b1);
        checkOutput("ovf empty", 64'(bus.m_valid), 64'd0);

        // Push into a full FIFO that is popped in the same cycle is accepted.
        doReset();
        for (int k = 0; k < 3; k++)
            applyStimulus(8'b0000_0001, packData(32'h200 + k, 0, 0, 0), 1'b0, 1'b0);
        applyStimulus(8'b0000_0001, packData(32'h203, 0, 0, 0), 1'b1, 1'b0);
        for (int k = 1; k < 4; k++) begin
            idle(1'b1);
            checkOutput("fullpop ovf",  64'(ovf),        64'd0);
            checkOutput("fullpop data", 64'(bus.m_data), 64'(32'h200 + k));
        end
        idle(1'b1);
        checkOutput("fullpop empty", 64'(bus.m_valid), 64'd0);

        // Asynchronous reset mid-transfer discards pending and queued words.
        doReset();
        applyStimulus(8'b0101_0101, packData(32'h300, 32'h301, 32'h302, 32'h303), 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        checkOutput("pre-reset valid", 64'(bus.m_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async m_valid", 64'(bus.m_valid), 64'd0);
        checkOutput("async m_data",  64'(bus.m_data),  64'd0);
        checkOutput("async m_core",  64'(bus.m_core),  64'd0);
        checkOutput("async m_addr",  64'(bus.m_addr),  64'd0);
        coreOutEn = '0;
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        applyStimulus(8'b0100_0000, packData(0, 0, 0, 32'h77), 1'b1, 1'b0);
        idle(1'b1);
        checkOutput("post-reset early", 64'(bus.m_valid), 64'd0);
        idle(1'b1);
        checkOutput("post-reset valid", 64'(bus.m_valid), 64'd1);
        checkOutput("post-reset data",  64'(bus.m_data),  64'h77);
        checkOutput("post-reset core",  64'(bus.m_core),  64'd3);
        repeat (4) idle(1'b1);

        // Random traffic: mostly-ready sink, then a mostly-stalled sink.
        for (int phase = 0; phase < 2; phase++) begin
            for (int n = 0; n < 1500; n++) begin
                en = '0;
                for (int i = 0; i < NC; i++)
                    if ($urandom_range(0, 3) == 0) en[i*NU +: NU] = NU'($urandom_range(1, 3));
                applyStimulus(en, {$urandom, $urandom, $urandom, $urandom},
                              (phase == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                              $urandom_range(0, 19) == 0);
            end
        end
        repeat (20) idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
